// File: rtl/cam_frame_writer.sv
// cam_frame_writer: assembles RGB565 camera byte pairs into pixels and frame-buffer writes.
// Define CAM_FRAME_WRITER_FRAME_COUNT_EN to add the frame_count_out counter.
module cam_frame_writer #(
    parameter int H_ACTIVE = 240,
    parameter int V_ACTIVE = 320
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        camera_pclk_in,
    input  logic        camera_hs_in,
    input  logic        camera_vs_in,
    input  logic [7:0]  camera_data_in,
    output logic        pixel_valid_out,
    output logic [15:0] pixel_data_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [16:0] bram_addr_out,
    output logic        bram_we_out,
    output logic        frame_done_out
`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
    ,
    output logic [7:0]  frame_count_out
`endif
);
    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] BYTE0      = 2'd1;
    localparam logic [1:0] BYTE1      = 2'd2;
    localparam logic [16:0] HA = 17'(H_ACTIVE);
    logic [1:0]  state;
    logic        pclk_prev, hs_prev, vs_prev, armed;
    logic [7:0]  high;
    logic [10:0] h, h_inc;
    logic [9:0]  v, v_inc;
    logic        pclk_edge, in_frame, vs_rise, vs_fall, hs_fall, byte_ok, emit, in_window;
    logic [16:0] addr_next;
    // armed blocks a frame start until vs has been seen low, so a reset never resumes a frame
    always_comb begin
        pclk_edge = camera_pclk_in & ~pclk_prev;
        in_frame  = state != WAIT_FRAME;
        vs_rise   = pclk_edge & ~in_frame & camera_vs_in & ~vs_prev & armed;
        vs_fall   = pclk_edge & in_frame & ~camera_vs_in & vs_prev;
        hs_fall   = pclk_edge & in_frame & ~camera_hs_in & hs_prev;
        byte_ok   = pclk_edge & in_frame & camera_hs_in & ~vs_fall & ~hs_fall;
        emit      = byte_ok & (state == BYTE1);
        h_inc     = (h == 11'h7FF) ? h : h + 11'd1;
        v_inc     = (v == 10'h3FF) ? v : v + 10'd1;
        in_window = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        addr_next = 17'(v) * HA + 17'(h);
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= WAIT_FRAME;
            pclk_prev       <= 1'b0;
            hs_prev         <= 1'b0;
            vs_prev         <= 1'b0;
            armed           <= 1'b0;
            high            <= 8'd0;
            h               <= 11'd0;
            v               <= 10'd0;
            pixel_valid_out <= 1'b0;
            pixel_data_out  <= 16'd0;
            hcount_out      <= 11'd0;
            vcount_out      <= 10'd0;
            bram_addr_out   <= 17'd0;
            bram_we_out     <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            pclk_prev       <= camera_pclk_in;
            pixel_valid_out <= emit;
            bram_we_out     <= emit & in_window;
            frame_done_out  <= vs_fall;
            if (pclk_edge) begin
                hs_prev <= camera_hs_in;
                vs_prev <= camera_vs_in;
                armed   <= armed | ~camera_vs_in;
            end
            if (emit) begin
                pixel_data_out <= {high, camera_data_in};
                hcount_out     <= h;
                vcount_out     <= v;
                bram_addr_out  <= addr_next;
            end
            if (vs_fall) begin
                state <= WAIT_FRAME;
                h     <= 11'd0;
                v     <= 10'd0;
            end else if (hs_fall) begin
                state <= BYTE0;
                h     <= 11'd0;
                v     <= v_inc;
            end else if (byte_ok) begin
                state <= (state == BYTE0) ? BYTE1 : BYTE0;
                high  <= (state == BYTE0) ? camera_data_in : high;
                h     <= (state == BYTE0) ? h : h_inc;
            end else if (vs_rise) begin
                state <= BYTE0;
                h     <= 11'd0;
                v     <= 10'd0;
            end
        end
    end
`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) frame_count_out <= 8'd0;
        else frame_count_out <= frame_count_out + {7'd0, frame_done_out};
    end
`endif
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: directed scenario bench for cam_frame_writer.
module tb_cam_frame_writer;
    logic        clk_in = 0, rst_in = 1;
    logic        camera_pclk_in = 0, camera_hs_in = 0, camera_vs_in = 0;
    logic [7:0]  camera_data_in = 0;
    logic        pixel_valid_out, bram_we_out, frame_done_out;
    logic [15:0] pixel_data_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [16:0] bram_addr_out;
`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
    logic [7:0]  frame_count_out;
`endif
    int errors = 0, checks = 0;
    int npix = 0, nwe = 0, ndone = 0, nlong = 0;
    logic done_q = 0;
    logic [15:0] p_data [4096];
    logic [10:0] p_h [4096];
    logic [9:0]  p_v [4096];
    logic [16:0] p_addr [4096];
    logic        p_we [4096];

    cam_frame_writer dut (
        .clk_in(clk_in), .rst_in(rst_in), .camera_pclk_in(camera_pclk_in),
        .camera_hs_in(camera_hs_in), .camera_vs_in(camera_vs_in), .camera_data_in(camera_data_in),
        .pixel_valid_out(pixel_valid_out), .pixel_data_out(pixel_data_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .bram_addr_out(bram_addr_out),
        .bram_we_out(bram_we_out), .frame_done_out(frame_done_out)
`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
        , .frame_count_out(frame_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (pixel_valid_out) begin
            p_data[npix % 4096] = pixel_data_out;
            p_h[npix % 4096]    = hcount_out;
            p_v[npix % 4096]    = vcount_out;
            p_addr[npix % 4096] = bram_addr_out;
            p_we[npix % 4096]   = bram_we_out;
            npix++;
        end
        if (bram_we_out) nwe++;
        if (frame_done_out) ndone++;
        if (frame_done_out && done_q) nlong++;
        done_q = frame_done_out;
    end

    task automatic send(input logic hs, input logic vs, input logic [7:0] d);
        camera_hs_in = hs;
        camera_vs_in = vs;
        camera_data_in = d;
        camera_pclk_in = 1;
        repeat (2) @(posedge clk_in);
        #1 camera_pclk_in = 0;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if ({pixel_valid_out, bram_we_out, frame_done_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 000", {pixel_valid_out, bram_we_out, frame_done_out});
        end
        checks++;
        if (pixel_data_out !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", pixel_data_out); end
        checks++;
        if ({hcount_out, vcount_out} !== 21'h0) begin errors++; $display("FAIL reset_counts got %0d,%0d want 0,0", hcount_out, vcount_out); end
        checks++;
        if (bram_addr_out !== 17'h0) begin errors++; $display("FAIL reset_addr got %0d want 0", bram_addr_out); end
        rst_in = 0;
        send(0, 0, 8'h00);
    endtask

    task automatic test_single_pixel;
        int b = npix, d = ndone;
        send(0, 1, 8'h00);
        send(1, 1, 8'hF8);
        send(1, 1, 8'h1F);
        checks++;
        if (npix - b !== 1) begin errors++; $display("FAIL single_count got %0d want 1", npix - b); end
        checks++;
        if (p_data[b % 4096] !== 16'hF81F) begin errors++; $display("FAIL single_data got %h want f81f", p_data[b % 4096]); end
        checks++;
        if ({p_h[b % 4096], p_v[b % 4096]} !== 21'h0) begin errors++; $display("FAIL single_hv got %0d,%0d want 0,0", p_h[b % 4096], p_v[b % 4096]); end
        checks++;
        if ({p_addr[b % 4096], p_we[b % 4096]} !== 18'h1) begin errors++; $display("FAIL single_addr_we got %0d,%b want 0,1", p_addr[b % 4096], p_we[b % 4096]); end
        send(0, 0, 8'h00);
        checks++;
        if (ndone - d !== 1) begin errors++; $display("FAIL single_done got %0d want 1", ndone - d); end
    endtask

    task automatic test_three_lines;
        int b = npix, w = nwe;
        send(0, 1, 8'h00);
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 242; p++) begin
                send(1, 1, 8'(p));
                send(1, 1, 8'(l));
            end
            send(0, 1, 8'h00);
        end
        checks++;
        if (npix - b !== 726) begin errors++; $display("FAIL lines_count got %0d want 726", npix - b); end
        checks++;
        if ({p_addr[(b + 725) % 4096], p_we[(b + 725) % 4096]} !== {17'd721, 1'b0}) begin
            errors++;
            $display("FAIL lines_241_2 got %0d,%b want 721,0", p_addr[(b + 725) % 4096], p_we[(b + 725) % 4096]);
        end
        checks++;
        if ({p_addr[(b + 723) % 4096], p_we[(b + 723) % 4096]} !== {17'd719, 1'b1}) begin
            errors++;
            $display("FAIL lines_239_2 got %0d,%b want 719,1", p_addr[(b + 723) % 4096], p_we[(b + 723) % 4096]);
        end
        checks++;
        if (p_data[(b + 725) % 4096] !== 16'hF102) begin errors++; $display("FAIL lines_data got %h want f102", p_data[(b + 725) % 4096]); end
        checks++;
        if ({p_h[(b + 725) % 4096], p_v[(b + 725) % 4096]} !== {11'd241, 10'd2}) begin
            errors++;
            $display("FAIL lines_hv got %0d,%0d want 241,2", p_h[(b + 725) % 4096], p_v[(b + 725) % 4096]);
        end
        checks++;
        if (nwe - w !== 720) begin errors++; $display("FAIL lines_writes got %0d want 720", nwe - w); end
        checks++;
        if (vcount_out !== 10'd2) begin errors++; $display("FAIL lines_vend got %0d want 2", vcount_out); end
        send(0, 0, 8'h00);
    endtask

    task automatic test_lone_byte;
        int b = npix;
        send(0, 1, 8'h00);
        send(1, 1, 8'hAB);
        send(0, 1, 8'h00);
        checks++;
        if (npix - b !== 0) begin errors++; $display("FAIL lone_nopix got %0d want 0", npix - b); end
        send(1, 1, 8'h12);
        send(1, 1, 8'h34);
        checks++;
        if (p_data[b % 4096] !== 16'h1234) begin errors++; $display("FAIL lone_data got %h want 1234", p_data[b % 4096]); end
        checks++;
        if ({p_h[b % 4096], p_v[b % 4096], p_addr[b % 4096]} !== {11'd0, 10'd1, 17'd240}) begin
            errors++;
            $display("FAIL lone_hva got %0d,%0d,%0d want 0,1,240", p_h[b % 4096], p_v[b % 4096], p_addr[b % 4096]);
        end
        send(0, 0, 8'h00);
    endtask

    task automatic test_vs_fall;
        int b = npix, d = ndone, lg = nlong;
        send(0, 1, 8'h00);
        send(1, 1, 8'h11);
        send(1, 1, 8'h22);
        send(1, 1, 8'h33);
        send(1, 0, 8'h44);
        checks++;
        if (ndone - d !== 1 || nlong !== lg) begin errors++; $display("FAIL vsfall_done got %0d pulses %0d long want 1,0", ndone - d, nlong - lg); end
        for (int i = 0; i < 4; i++) send(1, 0, 8'(8'h50 + i));
        checks++;
        if (npix - b !== 1) begin errors++; $display("FAIL vsfall_nopix got %0d want 1", npix - b); end
        checks++;
        if (p_data[b % 4096] !== 16'h1122) begin errors++; $display("FAIL vsfall_data got %h want 1122", p_data[b % 4096]); end
        checks++;
        if (frame_done_out !== 1'b0) begin errors++; $display("FAIL vsfall_idle got %b want 0", frame_done_out); end
    endtask

    task automatic test_reset_midline;
        int b, w, d;
        send(0, 1, 8'h00);
        send(1, 1, 8'h55);
        send(1, 1, 8'h66);
        send(1, 1, 8'h77);
        rst_in = 1;
        @(posedge clk_in);
        #1;
        checks++;
        if ({pixel_data_out, bram_addr_out, hcount_out, vcount_out} !== 54'h0) begin
            errors++;
            $display("FAIL midrst_outputs got %h,%0d,%0d,%0d want 0", pixel_data_out, bram_addr_out, hcount_out, vcount_out);
        end
        rst_in = 0;
        b = npix; w = nwe; d = ndone;
        send(1, 1, 8'h88);
        send(1, 1, 8'h99);
        send(0, 1, 8'h00);
        send(1, 1, 8'hAA);
        send(1, 1, 8'hBB);
        checks++;
        if (npix - b !== 0 || nwe - w !== 0) begin errors++; $display("FAIL midrst_suppress got %0d pix %0d we want 0,0", npix - b, nwe - w); end
        send(0, 0, 8'h00);
        checks++;
        if (ndone - d !== 0) begin errors++; $display("FAIL midrst_nodone got %0d want 0", ndone - d); end
        send(0, 1, 8'h00);
        send(1, 1, 8'h9A);
        send(1, 1, 8'hBC);
        checks++;
        if (npix - b !== 1 || nwe - w !== 1) begin errors++; $display("FAIL midrst_resume got %0d pix %0d we want 1,1", npix - b, nwe - w); end
        checks++;
        if ({p_data[b % 4096], p_addr[b % 4096]} !== {16'h9ABC, 17'd0}) begin
            errors++;
            $display("FAIL midrst_first got %h,%0d want 9abc,0", p_data[b % 4096], p_addr[b % 4096]);
        end
        send(0, 0, 8'h00);
    endtask

`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
    task automatic test_frame_count;
        rst_in = 1;
        @(posedge clk_in);
        #1 rst_in = 0;
        checks++;
        if (frame_count_out !== 8'd0) begin errors++; $display("FAIL fcount_reset got %0d want 0", frame_count_out); end
        send(0, 0, 8'h00);
        for (int i = 0; i < 257; i++) begin
            send(0, 1, 8'h00);
            send(0, 0, 8'h00);
        end
        checks++;
        if (frame_count_out !== 8'd1) begin errors++; $display("FAIL fcount_wrap got %0d want 1", frame_count_out); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_pixel;
        test_three_lines;
        test_lone_byte;
        test_vs_fall;
        test_reset_midline;
`ifdef CAM_FRAME_WRITER_FRAME_COUNT_EN
        test_frame_count;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
